// File: rtl/alu_arbiter_if.sv
// Bundled request/response ports for two requesters plus the shared ALU link.
// Function codes are 4-bit (alu_fn_t encoding) and words are 32-bit (word_t).
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_fn;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        resp0_valid;
    logic        resp0_ready;
    logic [31:0] resp0_r;

    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_fn;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        resp1_valid;
    logic        resp1_ready;
    logic [31:0] resp1_r;

    logic [3:0]  alu_fn;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_r;

    // arbiter side
    modport slave (
        input  req0_valid, req0_fn, req0_a, req0_b, resp0_ready,
        input  req1_valid, req1_fn, req1_a, req1_b, resp1_ready,
        input  alu_r,
        output req0_ready, resp0_valid, resp0_r,
        output req1_ready, resp1_valid, resp1_r,
        output alu_fn, alu_a, alu_b
    );

    // requester / ALU side
    modport master (
        output req0_valid, req0_fn, req0_a, req0_b, resp0_ready,
        output req1_valid, req1_fn, req1_a, req1_b, resp1_ready,
        output alu_r,
        input  req0_ready, resp0_valid, resp0_r,
        input  req1_ready, resp1_valid, resp1_r,
        input  alu_fn, alu_a, alu_b
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Operands are registered before reaching the ALU, result is registered
// before being returned; one operation is in flight at a time.
package Vermicodes_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } alu_fn_t;
endpackage

// state | meaning
// IDLE  | waiting for a request; grant is combinational
// EXEC  | operands registered, ALU result captured at the end of this cycle
// RESP  | result presented to the owner until it handshakes
module alu_arbiter
    import Vermicodes_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t  state_q, state_d;
    alu_fn_t fn_q;
    word_t   a_q, b_q, result_q;
    logic    owner_q;
    logic    last_q;
    logic    grant;
    logic    rdy0, rdy1;
    logic    rv0, rv1;
    logic    accept;
    logic    resp_hs;

    // Grant choice: lone requester wins; a tie goes to requester 0 in
    // fixed mode, otherwise to whoever was not served last.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            grant = FIXED_PRIORITY ? 1'b0 : ~last_q;
        else if (bus.req1_valid)
            grant = 1'b1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d = state_q;
        rdy0    = 1'b0;
        rdy1    = 1'b0;
        rv0     = 1'b0;
        rv1     = 1'b0;
        accept  = 1'b0;
        resp_hs = 1'b0;
        case (state_q)
            IDLE: begin
                rdy0   = ~grant & bus.req0_valid;
                rdy1   =  grant & bus.req1_valid;
                accept = rdy0 | rdy1;
                if (accept) state_d = EXEC;
            end
            EXEC: state_d = RESP;
            RESP: begin
                rv0     = ~owner_q;
                rv1     =  owner_q;
                resp_hs = owner_q ? bus.resp1_ready : bus.resp0_ready;
                if (resp_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand, owner, result and last-served registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fn_q     <= ALU_NOP;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            if (accept) begin
                fn_q    <= alu_fn_t'(grant ? bus.req1_fn : bus.req0_fn);
                a_q     <= grant ? bus.req1_a : bus.req0_a;
                b_q     <= grant ? bus.req1_b : bus.req0_b;
                owner_q <= grant;
            end
            if (state_q == EXEC) result_q <= bus.alu_r;
            if (resp_hs)         last_q   <= owner_q;
        end
    end

    assign bus.req0_ready  = rdy0;
    assign bus.req1_ready  = rdy1;
    assign bus.resp0_valid = rv0;
    assign bus.resp1_valid = rv1;
    assign bus.resp0_r     = result_q;
    assign bus.resp1_r     = result_q;
    assign bus.alu_fn      = fn_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
endmodule
